// File: rtl/g_3rr_arb.sv
// Three-requester round-robin arbiter with registered one-hot grants and a combined busy line.
// Optional build macro G_3RR_ARB_PARK_EN keeps the last grant parked while idle.
module g_3rr_arb #(
   parameter int HOLD_MAX = 4
) (
   input  logic       CK,
   input  logic       RN,
   input  logic       CE,
   input  logic       RA,
   input  logic       RB,
   input  logic       RC,
   output logic       GA,
   output logic       GB,
   output logic       GC,
   output logic       Y,
   output logic [1:0] dbg_state
);

   // Handshake: RA/RB/RC are level requests sampled at CK when CE=1; a grant
   // stays asserted each cycle the requester owns the resource.
   localparam int CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0] HOLD_C = CW'(HOLD_MAX);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GNT_A = 2'd1;
   localparam logic [1:0] GNT_B = 2'd2;
   localparam logic [1:0] GNT_C = 2'd3;

   // LAST is held as an index: 0=A, 1=B, 2=C.
   logic [1:0]    state, state_n;
   logic [1:0]    last, last_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    g, g_n;
   logic          y_q;
   logic [2:0]    req;
   logic [1:0]    cur;
   logic [2:0]    others;
   logic [1:0]    pick_all;
   logic [1:0]    pick_oth;
   logic          parked;

   function automatic logic [2:0] idx2oh(input logic [1:0] i);
      case (i)
         2'd0:    idx2oh = 3'b001;
         2'd1:    idx2oh = 3'b010;
         2'd2:    idx2oh = 3'b100;
         default: idx2oh = 3'b000;
      endcase
   endfunction

   // First requester after 'after' in A->B->C->A order; only meaningful if |r.
   function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] after);
      logic [1:0] o0, o1, o2;
      case (after)
         2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
         2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
         default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
      endcase
      if (r[o0])      rr_pick = o0;
      else if (r[o1]) rr_pick = o1;
      else            rr_pick = o2;
   endfunction

   assign req      = {RC, RB, RA};
   assign cur      = state - 2'd1;
   assign others   = req & ~idx2oh(cur);
   assign pick_all = rr_pick(req, last);
   assign pick_oth = rr_pick(others, cur);
   assign parked   = |g;

   always_comb begin
      state_n = state;
      last_n  = last;
      cnt_n   = cnt;
      if (state == IDLE) begin
`ifdef G_3RR_ARB_PARK_EN
         if (parked && req[last]) begin
            state_n = last + 2'd1;
            cnt_n   = CNT_ONE;
         end else if (|req) begin
            state_n = pick_all + 2'd1;
            last_n  = pick_all;
            cnt_n   = CNT_ONE;
         end
`else
         if (|req) begin
            state_n = pick_all + 2'd1;
            last_n  = pick_all;
            cnt_n   = CNT_ONE;
         end
`endif
      end else if (req[cur]) begin
         if (|others) begin
            if (HOLD_MAX != 0 && cnt == HOLD_C) begin
               state_n = pick_oth + 2'd1;
               last_n  = pick_oth;
               cnt_n   = CNT_ONE;
            end else if (HOLD_MAX != 0) begin
               cnt_n = cnt + CNT_ONE;
            end
         end else if (HOLD_MAX != 0 && cnt != HOLD_C) begin
            cnt_n = cnt + CNT_ONE;
         end
      end else if (|others) begin
         state_n = pick_oth + 2'd1;
         last_n  = pick_oth;
         cnt_n   = CNT_ONE;
      end else begin
         state_n = IDLE;
         cnt_n   = '0;
      end
   end

   always_comb begin
      g_n = 3'b000;
      if (state_n != IDLE) begin
         g_n = idx2oh(state_n - 2'd1);
      end else begin
`ifdef G_3RR_ARB_PARK_EN
         g_n = g;
`else
         g_n = 3'b000;
`endif
      end
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state <= IDLE;
         last  <= 2'd2;
         cnt   <= '0;
         g     <= 3'b000;
         y_q   <= 1'b0;
      end else if (CE) begin
         state <= state_n;
         last  <= last_n;
         cnt   <= cnt_n;
         g     <= g_n;
         y_q   <= |g_n;
      end
   end

   assign GA        = g[0];
   assign GB        = g[1];
   assign GC        = g[2];
   assign Y         = y_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_g_3rr_arb.sv
// Scoreboard bench for g_3rr_arb: HOLD_MAX=4 instance plus an unlimited-hold (HOLD_MAX=0) instance.
module tb_g_3rr_arb;

   localparam logic [3:0] NA = 4'b0000;
   localparam logic [3:0] XA = 4'b1001;
   localparam logic [3:0] XB = 4'b1010;
   localparam logic [3:0] XC = 4'b1100;
`ifdef G_3RR_ARB_PARK_EN
   localparam logic [3:0] IDLE_C = XC;
`else
   localparam logic [3:0] IDLE_C = NA;
`endif

   logic ck = 1'b0;
   logic rn, ce, ra, rb, rc, ra0, rb0;
   logic ga, gb, gc, y, ga0, gb0, gc0, y0;
   logic [1:0] st, st0;

   logic [7:0] exp_q[$];
   int tests_run = 0;
   int tests_failed = 0;
   int step_id = 0;

   always #5 ck = ~ck;

   g_3rr_arb #(.HOLD_MAX(4)) dut (
      .CK(ck), .RN(rn), .CE(ce), .RA(ra), .RB(rb), .RC(rc),
      .GA(ga), .GB(gb), .GC(gc), .Y(y), .dbg_state(st)
   );

   g_3rr_arb #(.HOLD_MAX(0)) dut0 (
      .CK(ck), .RN(rn), .CE(1'b1), .RA(ra0), .RB(rb0), .RC(1'b0),
      .GA(ga0), .GB(gb0), .GC(gc0), .Y(y0), .dbg_state(st0)
   );

   // Monitor: after each edge check invariants and pop one expected vector.
   always begin
      logic [7:0] act, e;
      @(posedge ck);
      #1;
      act = {y0, gc0, gb0, ga0, y, gc, gb, ga};
      tests_run++;
      if ($countones({gc, gb, ga}) > 1 || y !== (ga | gb | gc) ||
          $countones({gc0, gb0, ga0}) > 1 || y0 !== (ga0 | gb0 | gc0)) begin
         tests_failed++;
         $display("FAIL onehot_y t=%0t got %b required one-hot grants with Y=OR", $time, act);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         step_id++;
         tests_run++;
         if (act !== e) begin
            tests_failed++;
            $display("FAIL step%0d {Y0,GC0,GB0,GA0,Y,GC,GB,GA} got %b required %b", step_id, act, e);
         end
      end
   end

   task automatic step(input logic ce_i, input logic [2:0] req_i, input logic [1:0] req0_i,
                       input logic [7:0] exp_i);
      @(negedge ck);
      ce = ce_i;
      {rc, rb, ra} = req_i;
      {rb0, ra0} = req0_i;
      exp_q.push_back(exp_i);
   endtask

   task automatic check_zero(input string name);
      tests_run++;
      if ({y0, gc0, gb0, ga0, y, gc, gb, ga} !== 8'h00) begin
         tests_failed++;
         $display("FAIL %s got %b required 00000000", name, {y0, gc0, gb0, ga0, y, gc, gb, ga});
      end
   endtask

   initial begin
      logic [3:0] e;
      rn = 1'b0; ce = 1'b1;
      ra = 1'b0; rb = 1'b0; rc = 1'b0; ra0 = 1'b0; rb0 = 1'b0;
      repeat (2) @(posedge ck);
      @(negedge ck);
      ra = 1'b1; rb = 1'b1; rc = 1'b1; ra0 = 1'b1; rb0 = 1'b1;
      #1;
      check_zero("reset_hold");
      #1;
      rn = 1'b1;
      exp_q.push_back({XA, XA});
      // Fair rotation (4 cycles each) alongside unlimited hold on dut0.
      for (int i = 2; i <= 20; i++) begin
         case (((i - 1) / 4) % 3)
            0:       e = XA;
            1:       e = XB;
            default: e = XC;
         endcase
         step(1'b1, 3'b111, 2'b11, {XA, e});
      end
      step(1'b1, 3'b001, 2'b00, {NA, XA});
      // Handoff A->B without a bubble.
      step(1'b1, 3'b011, 2'b00, {NA, XA});
      step(1'b1, 3'b010, 2'b00, {NA, XB});
      // Idle return from C.
      step(1'b1, 3'b100, 2'b00, {NA, XC});
      step(1'b1, 3'b100, 2'b00, {NA, XC});
      step(1'b1, 3'b000, 2'b00, {NA, IDLE_C});
      step(1'b1, 3'b000, 2'b00, {NA, IDLE_C});
      // CE freeze while holding B.
      step(1'b1, 3'b010, 2'b00, {NA, XB});
      step(1'b0, 3'b100, 2'b00, {NA, XB});
      step(1'b0, 3'b100, 2'b00, {NA, XB});
      step(1'b0, 3'b100, 2'b00, {NA, XB});
      step(1'b1, 3'b100, 2'b00, {NA, XC});
      // Mid-grant asynchronous reset.
      @(posedge ck);
      #3;
      rn = 1'b0;
      #1;
      check_zero("reset_mid_grant");
      step(1'b1, 3'b111, 2'b00, {NA, XA});
      rn = 1'b1;
      // Search order after A is B, after B is C.
      step(1'b1, 3'b110, 2'b00, {NA, XB});
      step(1'b1, 3'b101, 2'b00, {NA, XC});
      step(1'b1, 3'b000, 2'b00, {NA, IDLE_C});
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge ck);
      #2;
      if (exp_q.size() > 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drain got %0d pending required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
